sc_image_decoder: RTL and testbench
===================================

// Module: sc_image_decoder
// PURPOSE
//  Stochastic-to-binary back end for the m*n stochastic image pipeline: takes the per-pixel
//  output bitstreams of the edge-detector array (one bit per pixel per clock) and converts
//  them to binary intensities by counting ones over a fixed window of 2**L valid samples.
//  Sits after the edge-detector array; results go to frame capture / scoreboard logic.
// PARAMETERS
//  m            32  image rows
//  n            32  image columns
//  L            8   log2 of stream length; output pixel width in bits
//  BORDER_ZERO  1   1: force row m-1 and column n-1 outputs to 0 (never driven by the detector array)
// PORTS
//  clk          in   1          rising-edge clock, sole clock domain
//  reset        in   1          synchronous, active-low reset
//  start        in   1          one-cycle request to decode a frame; honoured only in IDLE
//  s_valid      in   1          s[] carries a valid stochastic sample this cycle
//  s            in   [0:m*n-1]  1-bit stream per pixel, index i*n+j
//  busy         out  1          high in ACCUM
//  done         out  1          one-cycle pulse when a new frame is latched on pix
//  frame_valid  out  1          pix holds a complete decoded frame
//  pix          out  [0:m*n-1][L-1:0]  decoded pixel values
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state=IDLE, all counters 0, pix all 0, busy=0, done=0, frame_valid=0.
//   Applies from any state; an in-progress frame is discarded, not latched.
//  States: IDLE -> ACCUM on start; ACCUM -> LATCH after the 2**L-th valid sample; LATCH -> IDLE.
//  IDLE: start=1 clears cnt[k] (L+1 bits each) and sample counter (L+1 bits), enters ACCUM next cycle.
//   s/s_valid in the start cycle are NOT counted.
//  ACCUM: each cycle with s_valid=1: cnt[k] += s[k] for all k, samples += 1.
//   Cycles with s_valid=0 change nothing (s ignored).
//   When samples==2**L-1 and s_valid=1, that sample is counted and state -> LATCH.
//  LATCH (one cycle): pix registers are written at the edge entering LATCH, so done=1 and
//   frame_valid=1 are visible during LATCH together with the new pix.
//   Saturation: pix[k] = (cnt[k]==2**L) ? 2**L-1 : cnt[k][L-1:0].
//   If BORDER_ZERO: pix[k]=0 for i==m-1 or j==n-1.
//  Latency: done asserts the cycle after the final valid sample;
//   with s_valid held 1, done is 2**L+1 cycles after the start cycle.
//  pix and frame_valid hold between frames. A new start does not clear them;
//   they update only on the next LATCH.
//  start in ACCUM or LATCH is ignored (not queued); start in the cycle after done (IDLE) is accepted.
//  busy=1 exactly while in ACCUM; done is never high for two consecutive cycles.
// TESTING (m=n=4, L=4, BORDER_ZERO=1 unless noted)
//  1 start, s all 1, s_valid=1 x16 -> done at cycle 17 after start;
//    interior pix=15 (saturated from 16); border pix=0; frame_valid=1.
//  2 pixel 5 driven 1 on every 4th valid sample, pixel 0 all 0, pixel 6 all 1
//    -> pix[5]=4, pix[0]=0, pix[6]=15.
//  3 s_valid toggling 1/0, s=1 on invalid cycles, s=0 on valid cycles -> done 33 cycles after start,
//    all pix=0; s_valid=1 with s=1 in the start cycle is also not counted.
//  4 reset=0 after 8 valid samples of a frame following a completed frame
//    -> next cycle pix all 0, frame_valid=0, busy=0; a fresh start then decodes normally.
//  5 start pulsed mid-ACCUM and during LATCH -> ignored, single done;
//    start the cycle after done -> second frame; pix holds frame-1 values until second done.
//  6 BORDER_ZERO=0, s all 1 -> pix[15]=15 and all border pix=15.

Source files
------------

// File: rtl/sc_image_decoder_if.sv
// Frame-decode handshake and data bundle between the edge-detector array side (master)
// and the stochastic-to-binary decoder (slave).
interface sc_image_decoder_if #(
   parameter int m = 32,
   parameter int n = 32,
   parameter int L = 8
);
   logic                      start;
   logic                      s_valid;
   logic [0:m*n-1]            s;
   logic                      busy;
   logic                      done;
   logic                      frame_valid;
   logic [0:m*n-1][L-1:0]     pix;

   modport master (
      output start, s_valid, s,
      input  busy, done, frame_valid, pix
   );

   modport slave (
      input  start, s_valid, s,
      output busy, done, frame_valid, pix
   );
endinterface

// File: rtl/sc_image_decoder.sv
// Stochastic-to-binary image decoder: counts ones per pixel over 2**L valid samples
// and latches the saturated counts as an L-bit binary frame.
module sc_image_decoder #(
   parameter int m           = 32,
   parameter int n           = 32,
   parameter int L           = 8,
   parameter bit BORDER_ZERO = 1'b1
) (
   input logic               clk,
   input logic               reset,
   sc_image_decoder_if.slave bus
);
   localparam int NPIX = m * n;
   localparam logic [L:0] LAST_SAMPLE = {1'b0, {L{1'b1}}};

   typedef enum logic [1:0] {IDLE, ACCUM, LATCH} state_t;

   state_t                  state;
   logic [L:0]              samples;
   logic [L:0]              cnt     [NPIX];
   logic [L:0]              cnt_nxt [NPIX];
   logic [0:NPIX-1][L-1:0]  pix_r;
   logic                    busy_r;
   logic                    done_r;
   logic                    frame_valid_r;

   // A full window of ones gives 2**L, one past the largest L-bit value.
   function automatic logic [L-1:0] sat_pix(input logic [L:0] c);
      return c[L] ? {L{1'b1}} : c[L-1:0];
   endfunction

   function automatic bit is_border(input int k);
      return BORDER_ZERO && (((k / n) == m - 1) || ((k % n) == n - 1));
   endfunction

   always_comb begin
      for (int k = 0; k < NPIX; k++) begin
         cnt_nxt[k] = cnt[k] + {{L{1'b0}}, bus.s[k]};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         samples       <= '0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         frame_valid_r <= 1'b0;
         pix_r         <= '0;
         for (int k = 0; k < NPIX; k++) begin
            cnt[k] <= '0;
         end
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  samples <= '0;
                  for (int k = 0; k < NPIX; k++) begin
                     cnt[k] <= '0;
                  end
                  state  <= ACCUM;
                  busy_r <= 1'b1;
               end
            end
            ACCUM: begin
               if (bus.s_valid) begin
                  samples <= samples + 1'b1;
                  for (int k = 0; k < NPIX; k++) begin
                     cnt[k] <= cnt_nxt[k];
                  end
                  // Final sample goes straight into pix so done and the frame appear together.
                  if (samples == LAST_SAMPLE) begin
                     state         <= LATCH;
                     busy_r        <= 1'b0;
                     done_r        <= 1'b1;
                     frame_valid_r <= 1'b1;
                     for (int k = 0; k < NPIX; k++) begin
                        pix_r[k] <= is_border(k) ? '0 : sat_pix(cnt_nxt[k]);
                     end
                  end
               end
            end
            LATCH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.frame_valid = frame_valid_r;
   assign bus.pix         = pix_r;

endmodule

// File: tb/tb_sc_image_decoder.sv
// Randomized bench for sc_image_decoder (4x4, L=4) against a sample-queue reference model,
// with one bordered and one unbordered instance driven identically.
module tb_sc_image_decoder;
   localparam int M  = 4;
   localparam int N  = 4;
   localparam int LW = 4;
   localparam int NP = M * N;
   localparam int WIN = 1 << LW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic sv = 1'b0;
   logic [0:NP-1] s_drv = '0;

   sc_image_decoder_if #(.m(M), .n(N), .L(LW)) bus0 ();
   sc_image_decoder_if #(.m(M), .n(N), .L(LW)) bus1 ();

   assign bus0.start   = start;
   assign bus0.s_valid = sv;
   assign bus0.s       = s_drv;
   assign bus1.start   = start;
   assign bus1.s_valid = sv;
   assign bus1.s       = s_drv;

   sc_image_decoder #(.m(M), .n(N), .L(LW), .BORDER_ZERO(1'b1)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus0)
   );

   sc_image_decoder #(.m(M), .n(N), .L(LW), .BORDER_ZERO(1'b0)) dut_nb (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus1)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   // Reference model: collects the valid samples of the current frame and decodes on the last one.
   bit            active = 1'b0;
   bit            in_latch = 1'b0;
   logic [0:NP-1] q[$];
   logic          exp_busy = 1'b0;
   logic          exp_done = 1'b0;
   logic          exp_fv = 1'b0;
   logic [0:NP-1][LW-1:0] exp_pix = '0;
   logic [0:NP-1][LW-1:0] exp_pix_nb = '0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (!rst_n) begin
         active = 1'b0;
         in_latch = 1'b0;
         q.delete();
         exp_busy = 1'b0;
         exp_done = 1'b0;
         exp_fv = 1'b0;
         exp_pix = '0;
         exp_pix_nb = '0;
      end else begin
         exp_done = 1'b0;
         if (in_latch) begin
            in_latch = 1'b0;
         end else if (!active) begin
            if (start) begin
               active = 1'b1;
               q.delete();
            end
         end else if (sv) begin
            q.push_back(s_drv);
            if (q.size() == WIN) begin
               for (int k = 0; k < NP; k++) begin
                  int c;
                  int v;
                  c = 0;
                  foreach (q[t]) c += int'(q[t][k]);
                  v = (c > WIN - 1) ? WIN - 1 : c;
                  exp_pix_nb[k] = LW'(v);
                  exp_pix[k] = ((k / N) == M - 1 || (k % N) == N - 1) ? '0 : LW'(v);
               end
               active = 1'b0;
               in_latch = 1'b1;
               exp_done = 1'b1;
               exp_fv = 1'b1;
            end
         end
         exp_busy = active;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_val("busy", bus0.busy, exp_busy);
      check_val("done", bus0.done, exp_done);
      check_val("frame_valid", bus0.frame_valid, exp_fv);
      check_val("pix", bus0.pix, exp_pix);
      check_val("nb_busy", bus1.busy, exp_busy);
      check_val("nb_done", bus1.done, exp_done);
      check_val("nb_frame_valid", bus1.frame_valid, exp_fv);
      check_val("nb_pix", bus1.pix, exp_pix_nb);
   endtask

   // Issues a start (with a valid all-ones sample that must be ignored) and streams until done.
   task automatic frame(input int mode, input bit poke_start, output int lat);
      int v;
      v = 0;
      start = 1'b1;
      sv = 1'b1;
      s_drv = '1;
      step();
      lat = 1;
      start = 1'b0;
      while (!bus0.done) begin
         if (lat > 400) begin
            n_chk++;
            n_err++;
            $display("FAIL frame_timeout: got=no done expected=done mode=%0d", mode);
            return;
         end
         case (mode)
            0: begin
               sv = 1'b1;
               s_drv = '1;
            end
            1: begin
               sv = 1'b1;
               s_drv = NP'($urandom());
               s_drv[0] = 1'b0;
               s_drv[6] = 1'b1;
               s_drv[5] = ((v % 4) == 0);
            end
            2: begin
               sv = ((lat % 2) == 0);
               s_drv = sv ? '0 : '1;
            end
            default: begin
               sv = ($urandom_range(0, 3) != 0);
               s_drv = NP'($urandom());
            end
         endcase
         if (poke_start) start = ($urandom_range(0, 2) == 0);
         if (sv) v++;
         step();
         lat++;
      end
      start = 1'b0;
   endtask

   initial begin
      int lat;
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      check_val("rst_pix", bus0.pix, 64'd0);
      check_val("rst_frame_valid", bus0.frame_valid, 1'b0);

      frame(0, 1'b0, lat);
      check_val("t1_latency", lat, 17);
      check_val("t1_pix5", bus0.pix[5], 15);
      check_val("t1_pix3_border", bus0.pix[3], 0);
      check_val("t1_pix12_border", bus0.pix[12], 0);
      check_val("t6_nb_pix15", bus1.pix[15], 15);
      check_val("t6_nb_pix3", bus1.pix[3], 15);
      step();

      frame(1, 1'b0, lat);
      check_val("t2_latency", lat, 17);
      check_val("t2_pix5", bus0.pix[5], 4);
      check_val("t2_pix0", bus0.pix[0], 0);
      check_val("t2_pix6", bus0.pix[6], 15);
      step();

      frame(2, 1'b0, lat);
      check_val("t3_latency", lat, 33);
      check_val("t3_pix_zero", bus1.pix, 64'd0);
      step();

      frame(0, 1'b0, lat);
      step();
      start = 1'b1;
      sv = 1'b1;
      s_drv = '1;
      step();
      start = 1'b0;
      repeat (8) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_val("t4_pix", bus0.pix, 64'd0);
      check_val("t4_frame_valid", bus0.frame_valid, 1'b0);
      check_val("t4_busy", bus0.busy, 1'b0);
      step();
      frame(0, 1'b0, lat);
      check_val("t4_relatency", lat, 17);

      step();
      frame(3, 1'b1, lat);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      check_val("t5_latch_start_ignored", bus0.busy, 1'b0);
      frame(3, 1'b0, lat);
      step();
      frame(0, 1'b0, lat);
      check_val("t5_after_done_latency", lat, 17);

      for (int i = 0; i < 4; i++) begin
         step();
         frame(3, i[0], lat);
      end
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
